regin_bank: RTL and testbench
=============================

// Module: regin_bank
// PURPOSE
//   Parametrised bank of NUM_CH registers, each WIDTH bits, driving
//   instantiated-module inputs. It adds double buffering: writes land in a
//   shadow copy and a commit copies all shadows to the active outputs at once.
//   Immediate writes that bypass the shadow are also supported.
//   A sequenced soft-clear walks every channel back to RST_VAL.
//   Sits between a config/control master and downstream datapath blocks.
// PARAMETERS
//   WIDTH    8      bits per channel register
//   NUM_CH   4      number of channels (>=1)
//   RST_VAL  'h0    value loaded by rst and by soft-clear (WIDTH bits)
//   CHW      local: NUM_CH>1 ? $clog2(NUM_CH) : 1 (width of wr_ch)
// PORTS
//   clk       in   1             clock, all state on posedge
//   rst       in   1             synchronous reset, active-high
//   wr_valid  in   1             write request
//   wr_ready  out  1             bank can accept a write
//   wr_ch     in   CHW           target channel
//   wr_data   in   WIDTH         write data
//   wr_imm    in   1             1: write shadow+active; 0: shadow only
//   commit    in   1             pulse: copy all shadows to active
//   clr_req   in   1             pulse: start sequenced soft-clear
//   busy      out  1             soft-clear in progress
//   wr_err    out  1             1-cycle pulse: accepted write had wr_ch>=NUM_CH
//   dirty     out  NUM_CH        bit i: shadow[i] written since last commit/clear
//   q         out  NUM_CH*WIDTH  active registers; ch i at [i*WIDTH +: WIDTH]
// BEHAVIOUR
//   - Reset (rst=1 at edge): all active and shadow = RST_VAL; dirty=0; busy=0;
//     wr_err=0; state=IDLE. wr_ready is registered: it is 0 while rst is
//     asserted and 1 on the first cycle after rst deasserts.
//   - rst overrides everything, including a clear in progress.
//   - Handshake: a write is accepted when wr_valid & wr_ready at the edge.
//     wr_ch/wr_data/wr_imm are sampled only on acceptance. A held wr_valid
//     stalls while wr_ready=0.
//   - Latency: q and dirty reflect an accepted write or commit on the cycle
//     after the accepting edge (1 clk).
//   - wr_imm=1: shadow[ch] and active[ch] <= wr_data; dirty[ch] <= 0.
//   - wr_imm=0: shadow[ch] <= wr_data; dirty[ch] <= 1; active[ch] unchanged.
//   - wr_ch>=NUM_CH: the write is accepted (ready honoured) but causes no
//     state change; wr_err pulses for 1 cycle.
//   - commit in IDLE: active[i] <= shadow[i] for all i; dirty <= 0.
//     Commit in the same cycle as an accepted shadow write to ch k commits the
//     new wr_data for ch k (write-then-commit ordering); dirty[k] ends at 0.
//   - commit while busy: ignored, with no effect on a later cycle.
//   - FSM IDLE -> CLEAR on clr_req in IDLE. In CLEAR: busy=1, wr_ready=0.
//     Channel counter c runs 0..NUM_CH-1, one channel per cycle:
//     active[c] = shadow[c] = RST_VAL, dirty[c] = 0.
//     After c = NUM_CH-1 the FSM returns to IDLE, so busy is high for exactly
//     NUM_CH cycles and wr_ready rises the cycle busy falls.
//   - clr_req while busy: ignored.
//   - clr_req together with an accepted write and/or commit: the write and
//     commit complete first, then the clear starts on the next cycle and
//     overwrites them.
//   - Non-cleared channels keep their values during CLEAR; q remains valid.
// TESTING  (WIDTH=8, NUM_CH=4, RST_VAL=0 unless stated)
//   1. rst high 2 cycles -> q=0, dirty=0, busy=0, wr_ready=0 during rst and
//      1 on the first cycle after.
//   2. Imm write ch2=0x42 -> next cycle q[23:16]=0x42, other chans 0, dirty=0.
//   3. Shadow write ch1=0xA5 then ch3=0x3C -> q unchanged, dirty=4'b1010;
//      commit -> q[15:8]=0xA5, q[31:24]=0x3C, dirty=0.
//   4. Shadow write ch0=0x11 with commit in the same cycle -> next cycle
//      q[7:0]=0x11, dirty=0.
//   5. Load all chans 0xFF, then clr_req with wr_valid held high
//      -> busy=1 for 4 cycles, wr_ready=0; the write is accepted after busy
//      falls; q=0 except the written channel.
//   6. NUM_CH=3: wr_ch=3 -> wr_err 1-cycle pulse, q/dirty unchanged; rst on
//      the 2nd CLEAR cycle -> next cycle busy=0, all q=RST_VAL.

Source files
------------

// File: rtl/regin_bank.sv
// regin_bank: a bank of NUM_CH double-buffered configuration registers.
// Each channel has a shadow copy and an active copy. Writes normally land in
// the shadow copy, and a commit copies every shadow to its active copy at once.
// An immediate write updates both copies. A sequenced soft-clear walks the
// channels back to RST_VAL, one channel per cycle.
module regin_bank #(
  parameter int unsigned        WIDTH   = 8,
  parameter int unsigned        NUM_CH  = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int unsigned       CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [CHW-1:0]          wr_ch,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    wr_imm,
  input  logic                    commit,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    wr_err,
  output logic [NUM_CH-1:0]       dirty,
  output logic [NUM_CH*WIDTH-1:0] q
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
  localparam logic [CHW:0]   NUM_CH_W = (CHW + 1)'(NUM_CH);

  state_t             state_q;
  logic [CHW-1:0]     clr_cnt_q;
  logic               busy_q;
  logic               wr_ready_q;
  logic               wr_err_q;

  logic [WIDTH-1:0]   shadow_q [NUM_CH];
  logic [WIDTH-1:0]   shadow_d [NUM_CH];
  logic [WIDTH-1:0]   active_q [NUM_CH];
  logic [WIDTH-1:0]   active_d [NUM_CH];
  logic [NUM_CH-1:0]  dirty_q;
  logic [NUM_CH-1:0]  dirty_d;

  logic               wr_acc;
  logic               wr_oor;

  // A write is accepted only while ready, and ready is only high in IDLE
  assign wr_acc = wr_valid & wr_ready_q;
  assign wr_oor = ({1'b0, wr_ch} >= NUM_CH_W);

  // Per-channel next state: the clear step in CLEAR, otherwise a write then a commit
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      dirty_d[i]  = dirty_q[i];
      if (state_q == S_CLEAR) begin
        if (clr_cnt_q == CHW'(i)) begin
          shadow_d[i] = RST_VAL;
          active_d[i] = RST_VAL;
          dirty_d[i]  = 1'b0;
        end
      end else begin
        // The write goes into shadow_d first, so a commit in the same cycle
        // copies the freshly written value (write-then-commit ordering).
        if (wr_acc && (wr_ch == CHW'(i))) begin
          shadow_d[i] = wr_data;
          if (wr_imm) begin
            active_d[i] = wr_data;
            dirty_d[i]  = 1'b0;
          end else begin
            dirty_d[i]  = 1'b1;
          end
        end
        if (commit) begin
          active_d[i] = shadow_d[i];
          dirty_d[i]  = 1'b0;
        end
      end
    end
  end

  // Register bank state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= RST_VAL;
        active_q[i] <= RST_VAL;
      end
      dirty_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      dirty_q <= dirty_d;
    end
  end

  // Control FSM with registered busy, wr_ready and wr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_err_q <= wr_acc & wr_oor;
      case (state_q)
        S_IDLE: begin
          clr_cnt_q <= '0;
          if (clr_req) begin
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
          end else begin
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == LAST_CH) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end else begin
            clr_cnt_q  <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          clr_cnt_q  <= '0;
          busy_q     <= 1'b0;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Flatten the active copies onto the output bus
  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      q[i*WIDTH +: WIDTH] = active_q[i];
    end
  end

  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign wr_err   = wr_err_q;
  assign dirty    = dirty_q;

endmodule

// File: tb/tb_regin_bank.sv
// Directed testbench for regin_bank: a 4-channel bank (a_*) and a
// 3-channel bank (b_*) for out-of-range writes and reset during a clear.
module tb_regin_bank;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_errors;

  // 4-channel instance
  logic        a_rst, a_wr_valid, a_wr_ready, a_wr_imm, a_commit, a_clr_req;
  logic        a_busy, a_wr_err;
  logic [1:0]  a_wr_ch;
  logic [7:0]  a_wr_data;
  logic [3:0]  a_dirty;
  logic [31:0] a_q;

  // 3-channel instance
  logic        b_rst, b_wr_valid, b_wr_ready, b_wr_imm, b_commit, b_clr_req;
  logic        b_busy, b_wr_err;
  logic [1:0]  b_wr_ch;
  logic [7:0]  b_wr_data;
  logic [2:0]  b_dirty;
  logic [23:0] b_q;

  regin_bank #(.WIDTH(8), .NUM_CH(4), .RST_VAL(8'h00)) u_dut_a (
    .clk(clk), .rst(a_rst), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .wr_ch(a_wr_ch), .wr_data(a_wr_data), .wr_imm(a_wr_imm),
    .commit(a_commit), .clr_req(a_clr_req), .busy(a_busy),
    .wr_err(a_wr_err), .dirty(a_dirty), .q(a_q)
  );

  regin_bank #(.WIDTH(8), .NUM_CH(3), .RST_VAL(8'h00)) u_dut_b (
    .clk(clk), .rst(b_rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_ch(b_wr_ch), .wr_data(b_wr_data), .wr_imm(b_wr_imm),
    .commit(b_commit), .clr_req(b_clr_req), .busy(b_busy),
    .wr_err(b_wr_err), .dirty(b_dirty), .q(b_q)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [1:0] ch, input logic [7:0] data, input logic imm);
    a_wr_valid = 1'b1; a_wr_ch = ch; a_wr_data = data; a_wr_imm = imm;
    tick();
    a_wr_valid = 1'b0;
  endtask

  task automatic b_write(input logic [1:0] ch, input logic [7:0] data, input logic imm);
    b_wr_valid = 1'b1; b_wr_ch = ch; b_wr_data = data; b_wr_imm = imm;
    tick();
    b_wr_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    a_rst = 1'b1; a_wr_valid = 1'b0; a_wr_ch = '0; a_wr_data = '0;
    a_wr_imm = 1'b0; a_commit = 1'b0; a_clr_req = 1'b0;
    b_rst = 1'b1; b_wr_valid = 1'b0; b_wr_ch = '0; b_wr_data = '0;
    b_wr_imm = 1'b0; b_commit = 1'b0; b_clr_req = 1'b0;

    // 1. reset for two cycles
    tick();
    chk("rst_ready0", a_wr_ready, 0);
    tick();
    chk("rst_ready1", a_wr_ready, 0);
    chk("rst_q", a_q, 0);
    chk("rst_dirty", a_dirty, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_err", a_wr_err, 0);
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    chk("ready_after_rst", a_wr_ready, 1);
    chk("b_ready_after_rst", b_wr_ready, 1);

    // 2. immediate write
    a_write(2'd2, 8'h42, 1'b1);
    chk("imm_q", a_q, 32'h0042_0000);
    chk("imm_dirty", a_dirty, 0);

    // 3. shadow writes then commit
    a_write(2'd1, 8'hA5, 1'b0);
    a_write(2'd3, 8'h3C, 1'b0);
    chk("shadow_q", a_q, 32'h0042_0000);
    chk("shadow_dirty", a_dirty, 4'b1010);
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    chk("commit_q", a_q, 32'h3C42_A500);
    chk("commit_dirty", a_dirty, 0);

    // 4. shadow write with commit in the same cycle
    a_commit = 1'b1;
    a_write(2'd0, 8'h11, 1'b0);
    a_commit = 1'b0;
    chk("wrcommit_q", a_q, 32'h3C42_A511);
    chk("wrcommit_dirty", a_dirty, 0);

    // 5. load all, then clear with a held write request
    for (int i = 0; i < 4; i++) a_write(2'(i), 8'hFF, 1'b1);
    chk("loadall_q", a_q, 32'hFFFF_FFFF);
    a_clr_req = 1'b1;
    a_wr_valid = 1'b1; a_wr_ch = 2'd1; a_wr_data = 8'h77; a_wr_imm = 1'b1;
    tick();
    // the write accepted alongside clr_req lands before the clear starts
    a_clr_req = 1'b0;
    a_wr_data = 8'h99;
    chk("clr_busy0", a_busy, 1);
    chk("clr_ready0", a_wr_ready, 0);
    chk("clr_wr_first_q", a_q, 32'hFFFF_77FF);
    a_commit = 1'b1;               // ignored while busy
    tick();
    a_commit = 1'b0;
    a_clr_req = 1'b1;              // ignored while busy
    chk("clr_busy1", a_busy, 1);
    chk("clr_ready1", a_wr_ready, 0);
    chk("clr_partial_q", a_q, 32'hFFFF_7700);
    tick();
    a_clr_req = 1'b0;
    chk("clr_busy2", a_busy, 1);
    chk("clr_keep_q", a_q, 32'hFFFF_0000);
    tick();
    chk("clr_busy3", a_busy, 1);
    chk("clr_ready3", a_wr_ready, 0);
    tick();
    chk("clr_busy_fall", a_busy, 0);
    chk("clr_ready_rise", a_wr_ready, 1);
    chk("clr_done_q", a_q, 0);
    chk("clr_done_dirty", a_dirty, 0);
    tick();
    a_wr_valid = 1'b0;
    chk("held_write_q", a_q, 32'h0000_9900);
    tick();
    chk("no_restart_busy", a_busy, 0);

    // 6. NUM_CH=3: out-of-range write, then reset during clear
    b_write(2'd2, 8'h5A, 1'b1);
    b_write(2'd0, 8'h12, 1'b0);
    chk("b_setup_q", b_q, 24'h5A_0000);
    chk("b_setup_dirty", b_dirty, 3'b001);
    b_write(2'd3, 8'hEE, 1'b1);
    chk("b_err_pulse", b_wr_err, 1);
    chk("b_err_q", b_q, 24'h5A_0000);
    chk("b_err_dirty", b_dirty, 3'b001);
    tick();
    chk("b_err_clear", b_wr_err, 0);
    b_clr_req = 1'b1;
    tick();
    b_clr_req = 1'b0;
    chk("b_clr_busy", b_busy, 1);
    tick();
    chk("b_clr_keep_q", b_q, 24'h5A_0000);
    chk("b_clr_dirty", b_dirty, 3'b000);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    chk("b_rst_busy", b_busy, 0);
    chk("b_rst_q", b_q, 0);
    chk("b_rst_ready", b_wr_ready, 0);
    tick();
    chk("b_ready_back", b_wr_ready, 1);
    chk("b_idle_busy", b_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
